// File: rtl/strobe_out_ctrl_if.sv
// Control, configuration and status bundle for strobe_out_ctrl.
// master drives the controls, slave is the strobe controller.
interface strobe_out_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_acquisition_start;
  logic             i_stream_enable;
  logic             i_fval;
  logic             i_strobe_filter;
  logic [CNT_W-1:0] iv_strobe_delay;
  logic [CNT_W-1:0] iv_strobe_width;
  logic             i_strobe_mode;
  logic             i_strobe_polarity;
  logic             o_strobe;
  logic             o_busy;
  logic [15:0]      ov_strobe_miss_cnt;

  modport master (
    output i_acquisition_start, i_stream_enable, i_fval, i_strobe_filter,
    output iv_strobe_delay, iv_strobe_width, i_strobe_mode, i_strobe_polarity,
    input  o_strobe, o_busy, ov_strobe_miss_cnt
  );

  modport slave (
    input  i_acquisition_start, i_stream_enable, i_fval, i_strobe_filter,
    input  iv_strobe_delay, iv_strobe_width, i_strobe_mode, i_strobe_polarity,
    output o_strobe, o_busy, ov_strobe_miss_cnt
  );
endinterface

// File: rtl/strobe_out_ctrl.sv
// Delayed flash/strobe pulse generator (fixed-width or follow-input length).
// Define STROBE_MISS_CNT_EN to build the dropped-strobe counter.
module strobe_out_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  strobe_out_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDelay, StActive} state_e;

  state_e           state_q, state_d;
  logic             en_q, strb_q, strobe_q;
  logic [CNT_W-1:0] dly_sh_q, wid_sh_q;
  logic             mode_sh_q, pol_sh_q;
  logic [CNT_W-1:0] dly_cnt_q, act_cnt_q, len_cnt_q;
  logic             len_run_q;

  logic             rise, start, fallen, dly_done, act_done;
  logic [CNT_W-1:0] wid_eff;
  logic [CNT_W:0]   dly_cnt_inc, act_cnt_inc;

  assign rise        = bus.i_strobe_filter & ~strb_q;
  assign start       = rise & en_q & (state_q == StIdle);
  assign fallen      = ~len_run_q | ~bus.i_strobe_filter;
  assign wid_eff     = (wid_sh_q == '0) ? CNT_W'(1) : wid_sh_q;
  assign dly_cnt_inc = {1'b0, dly_cnt_q} + (CNT_W+1)'(1);
  assign act_cnt_inc = {1'b0, act_cnt_q} + (CNT_W+1)'(1);
  assign dly_done    = dly_cnt_inc >= {1'b0, dly_sh_q};
  // Follow mode may only stop once the input pulse is over and its length is matched.
  assign act_done    = mode_sh_q ? (act_cnt_inc >= {1'b0, wid_eff})
                                 : (fallen && (act_cnt_inc >= {1'b0, len_cnt_q}));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = (dly_sh_q != '0) ? StDelay : StActive;
      StDelay:  if (dly_done) state_d = StActive;
      StActive: if (act_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (!en_q) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      strb_q    <= 1'b0;
      strobe_q  <= 1'b0;
      dly_sh_q  <= '0;
      wid_sh_q  <= '0;
      mode_sh_q <= 1'b0;
      pol_sh_q  <= 1'b1;
      dly_cnt_q <= '0;
      act_cnt_q <= '0;
      len_cnt_q <= '0;
      len_run_q <= 1'b0;
    end else begin
      en_q     <= bus.i_acquisition_start & bus.i_stream_enable;
      strb_q   <= bus.i_strobe_filter;
      state_q  <= state_d;
      strobe_q <= (state_d == StActive) ? pol_sh_q : ~pol_sh_q;
      // A pulse being launched keeps the settings it was decided with.
      if ((state_q == StIdle) && !bus.i_fval && !start) begin
        dly_sh_q  <= bus.iv_strobe_delay;
        wid_sh_q  <= bus.iv_strobe_width;
        mode_sh_q <= bus.i_strobe_mode;
        pol_sh_q  <= bus.i_strobe_polarity;
      end
      if (state_d == StIdle) begin
        dly_cnt_q <= '0;
        act_cnt_q <= '0;
        len_cnt_q <= '0;
        len_run_q <= 1'b0;
      end else begin
        if (start) begin
          len_cnt_q <= CNT_W'(1);
          len_run_q <= 1'b1;
        end else if (len_run_q) begin
          if (!bus.i_strobe_filter) len_run_q <= 1'b0;
          else if (len_cnt_q != '1) len_cnt_q <= len_cnt_q + CNT_W'(1);
        end
        if ((state_q == StDelay) && (state_d == StDelay)) dly_cnt_q <= dly_cnt_q + CNT_W'(1);
        if ((state_q == StActive) && (act_cnt_q != '1)) act_cnt_q <= act_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.o_strobe = strobe_q;
  assign bus.o_busy   = (state_q != StIdle);

`ifdef STROBE_MISS_CNT_EN
  logic [15:0] miss_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_q <= 16'h0000;
    end else if (rise && (state_q != StIdle) && (miss_q != 16'hffff)) begin
      miss_q <= miss_q + 16'h0001;
    end
  end

  assign bus.ov_strobe_miss_cnt = miss_q;
`else
  assign bus.ov_strobe_miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_strobe_out_ctrl.sv
// Randomized self-checking bench for strobe_out_ctrl against a timestamp-based
// pulse-window model, plus directed scenarios for the key timing cases.
module tb_strobe_out_ctrl;

  localparam int CntW = 16;
`ifdef STROBE_MISS_CNT_EN
  localparam int MissEn = 1;
`else
  localparam int MissEn = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  strobe_out_ctrl_if #(.CNT_W(CntW)) bus ();

  strobe_out_ctrl #(.CNT_W(CntW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: each accepted rise defines a busy window [rise, busy_until) and an
  // active window starting at rise + delay, in edge indices.
  int k = 0;
  int m_busy_until = -1;
  int m_act_lo = 0;
  int m_rise_k = 0;
  int m_d = 0, m_w = 0;
  bit m_mode = 0, m_pol = 1, m_en = 0, m_prev_in = 0;
  int m_miss = 0;
  bit m_exp_busy, m_exp_strobe;
  int cur_len = 1;

  int hi_cnt, busy_cnt, first_k;
  bit meas_pol = 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    m_busy_until = -1;
    m_d = 0; m_w = 0; m_mode = 0; m_pol = 1;
    m_en = 0; m_prev_in = 0; m_miss = 0;
  endtask

  task automatic model_edge();
    bit rise, busy_b, acc;
    int len;
    rise   = bus.i_strobe_filter && !m_prev_in;
    busy_b = (k <= m_busy_until);
    acc    = 0;
    if (rise && busy_b && m_miss < 16'hffff) m_miss++;
    if (!m_en) begin
      if (busy_b) m_busy_until = k;
    end else if (rise && !busy_b) begin
      acc = 1;
      len = m_mode ? ((m_w == 0) ? 1 : m_w) : cur_len;
      m_rise_k = k;
      m_act_lo = k + m_d;
      m_busy_until = k + m_d + len;
    end
    m_exp_busy   = (k < m_busy_until);
    m_exp_strobe = (m_exp_busy && k >= m_act_lo) ? m_pol : !m_pol;
    if (!busy_b && !bus.i_fval && !acc) begin
      m_d    = int'(bus.iv_strobe_delay);
      m_w    = int'(bus.iv_strobe_width);
      m_mode = bus.i_strobe_mode;
      m_pol  = bus.i_strobe_polarity;
    end
    m_en      = bus.i_acquisition_start && bus.i_stream_enable;
    m_prev_in = bus.i_strobe_filter;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("strobe", bus.o_strobe, m_exp_strobe);
    check_eq("busy", bus.o_busy, m_exp_busy);
    check_eq("miss", bus.ov_strobe_miss_cnt, MissEn ? m_miss : 0);
    if (bus.o_strobe == meas_pol) begin
      hi_cnt++;
      if (first_k < 0) first_k = k;
    end
    if (bus.o_busy) busy_cnt++;
    k++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clr_stats();
    hi_cnt = 0; busy_cnt = 0; first_k = -1;
  endtask

  task automatic apply_reset(input int hold);
    reset_n = 1'b0;
    #1;
    check_eq("rst_strobe", bus.o_strobe, 0);
    check_eq("rst_busy", bus.o_busy, 0);
    check_eq("rst_miss", bus.ov_strobe_miss_cnt, 0);
    model_reset();
    repeat (hold) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_pulse(input int h, input int g);
    bus.i_strobe_filter = 1'b1;
    cur_len = h;
    steps(h);
    bus.i_strobe_filter = 1'b0;
    steps(g);
  endtask

  task automatic set_cfg(input bit mode, input int d, input int w, input bit pol);
    bus.i_strobe_mode     = mode;
    bus.iv_strobe_delay   = CntW'(d);
    bus.iv_strobe_width   = CntW'(w);
    bus.i_strobe_polarity = pol;
  endtask

  initial begin
    bus.i_acquisition_start = 1'b0;
    bus.i_stream_enable     = 1'b0;
    bus.i_fval              = 1'b0;
    bus.i_strobe_filter     = 1'b0;
    set_cfg(0, 0, 0, 1);
    clr_stats();
    apply_reset(2);

    // Fixed mode, no delay, width 10 against a 50-cycle input.
    bus.i_acquisition_start = 1'b1;
    bus.i_stream_enable     = 1'b1;
    set_cfg(1, 0, 10, 1);
    meas_pol = 1;
    steps(3);
    clr_stats();
    run_pulse(50, 20);
    check_eq("lat_fixed", first_k - m_rise_k + 1, 1);
    check_eq("hi_fixed", hi_cnt, 10);
    check_eq("busy_fixed", busy_cnt, 10);

    // Follow mode, delay 100, 37-cycle input.
    set_cfg(0, 100, 0, 1);
    steps(3);
    clr_stats();
    run_pulse(37, 150);
    check_eq("lat_follow", first_k - m_rise_k + 1, 101);
    check_eq("hi_follow", hi_cnt, 37);
    check_eq("busy_follow", busy_cnt, 137);

    // Second rise while a 200-cycle pulse is running.
    apply_reset(2);
    set_cfg(1, 0, 200, 1);
    steps(3);
    clr_stats();
    run_pulse(10, 40);
    run_pulse(10, 200);
    check_eq("hi_miss", hi_cnt, 200);
    check_eq("miss_once", bus.ov_strobe_miss_cnt, MissEn);

    // Delay change while fval high and busy only takes effect after fval drops.
    set_cfg(1, 10, 5, 1);
    steps(3);
    bus.i_fval = 1'b1;
    clr_stats();
    bus.i_strobe_filter = 1'b1;
    cur_len = 3;
    step();
    bus.iv_strobe_delay = CntW'(20);
    steps(2);
    bus.i_strobe_filter = 1'b0;
    steps(35);
    check_eq("lat_old_delay", first_k - m_rise_k + 1, 11);
    bus.i_fval = 1'b0;
    steps(3);
    clr_stats();
    run_pulse(3, 40);
    check_eq("lat_new_delay", first_k - m_rise_k + 1, 21);

    // Stream enable dropped mid-pulse.
    set_cfg(1, 0, 500, 1);
    steps(3);
    bus.i_strobe_filter = 1'b1;
    cur_len = 5;
    steps(5);
    bus.i_strobe_filter = 1'b0;
    steps(20);
    bus.i_stream_enable = 1'b0;
    steps(2);
    check_eq("abort_busy", bus.o_busy, 0);
    check_eq("abort_strobe", bus.o_strobe, 0);
    steps(3);
    bus.i_stream_enable = 1'b1;
    steps(3);

    // Active-low output, then reset in the middle of a pulse.
    set_cfg(1, 0, 5, 0);
    steps(3);
    check_eq("idle_low_pol", bus.o_strobe, 1);
    bus.i_strobe_filter = 1'b1;
    cur_len = 20;
    steps(3);
    check_eq("mid_low_pol", bus.o_strobe, 0);
    apply_reset(2);
    clr_stats();
    steps(10);
    bus.i_strobe_filter = 1'b0;
    steps(5);
    check_eq("no_resume", busy_cnt, 0);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 30), $urandom_range(0, 40),
                1'($urandom_range(0, 1)));
      bus.i_fval = 1'($urandom_range(0, 1));
      bus.i_acquisition_start = ($urandom_range(0, 11) != 0);
      bus.i_stream_enable     = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 39) == 0) apply_reset(1);
      run_pulse($urandom_range(1, 40), $urandom_range(1, 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
